// File: rtl/seq_match_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_match_pkg : shared types, ASCII constants and reset values            |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package seq_match_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [7:0] C_A = 8'h41, C_B = 8'h42, C_C = 8'h43, C_D = 8'h44,
                         C_E = 8'h45, C_F = 8'h46, C_G = 8'h47, C_H = 8'h48,
                         C_I = 8'h49, C_J = 8'h4A, C_K = 8'h4B, C_L = 8'h4C,
                         C_M = 8'h4D, C_N = 8'h4E, C_O = 8'h4F, C_P = 8'h50,
                         C_Q = 8'h51, C_R = 8'h52, C_S = 8'h53, C_T = 8'h54,
                         C_U = 8'h55, C_V = 8'h56, C_W = 8'h57, C_X = 8'h58,
                         C_Y = 8'h59, C_Z = 8'h5A;

  localparam state_t     C_RST_STATE = LOAD;
  localparam logic       C_RST_BIT   = 1'b0;
  localparam logic [7:0] C_RST_CHAR  = 8'h00;

endpackage
`default_nettype wire

// File: rtl/seq_match_arb_rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arb : combinational round-robin grant, scanning upward from i_ptr      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module rr_arb #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx
);

  function automatic int wrap(input int p, input int o);
    return (p + o) % NREQ;
  endfunction

  // Scan from farthest to nearest so the requester closest to i_ptr wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      if (i_req[wrap(int'(i_ptr), off)]) begin
        o_grant = NREQ'(1) << wrap(int'(i_ptr), off);
        o_idx   = IDW'(wrap(int'(i_ptr), off));
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_match_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_match_arb : one programmable pattern matcher shared round-robin by    |
// | NREQ byte streams. Optional MATCH_CNT_EN adds per-stream match counters.  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module seq_match_arb
  import seq_match_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int PMAX = 8,
  parameter int IW   = 4   // 2**IW >= PMAX+1 so a full-length pattern fits cfg_len
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_we,
  input  logic [IW-1:0]             cfg_addr,
  input  logic [7:0]                cfg_data,
  input  logic [IW-1:0]             cfg_len,
  input  logic                      cfg_start,
  input  logic                      cfg_stop,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*8-1:0]         din,
`ifdef MATCH_CNT_EN
  input  logic [$clog2(NREQ)-1:0]   cnt_sel,
  output logic [15:0]               match_cnt,
`endif
  output logic [NREQ-1:0]           ack,
  output logic                      running,
  output logic                      eureka,
  output logic [$clog2(NREQ)-1:0]   eureka_id
);

  localparam int            IDW    = $clog2(NREQ);
  localparam logic [IW:0]   C_PMAX = (IW + 1)'(PMAX);

  state_t           r_state;
  logic             r_running;
  logic             r_eureka;
  logic [IDW-1:0]   r_eid;
  logic [IDW-1:0]   r_ptr;
  logic [IW-1:0]    r_len;
  logic [7:0]       r_pat [2**IW];
  logic [IW-1:0]    r_ctx [NREQ];

  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_gidx;
  logic [IDW-1:0]   w_ptr_nxt;
  logic [7:0]       w_din [NREQ];
  logic [7:0]       w_c;
  logic [IW-1:0]    w_k;
  logic             w_any, w_accept, w_hit, w_first, w_last, w_start_ok;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_din
    assign w_din[gi] = din[8*gi +: 8];
  end

  rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx)
  );

  assign w_any      = |req;
  assign w_accept   = (r_state == RUN) && !cfg_stop && w_any;
  assign ack        = w_accept ? w_grant : '0;
  assign w_ptr_nxt  = (w_gidx == IDW'(NREQ - 1)) ? '0 : w_gidx + IDW'(1);
  assign w_k        = r_ctx[w_gidx];
  assign w_c        = w_din[w_gidx];
  assign w_hit      = (w_c == r_pat[w_k]);
  assign w_first    = (w_c == r_pat[0]);
  assign w_last     = (({1'b0, w_k} + (IW + 1)'(1)) == {1'b0, r_len});
  assign w_start_ok = cfg_start && (cfg_len != '0) && ({1'b0, cfg_len} <= C_PMAX);

  assign running    = r_running;
  assign eureka     = r_eureka;
  assign eureka_id  = r_eid;

`ifdef MATCH_CNT_EN
  logic [15:0] r_cnt [NREQ];
  assign match_cnt = r_cnt[cnt_sel];
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= C_RST_STATE;
      r_running <= C_RST_BIT;
      r_eureka  <= C_RST_BIT;
      r_eid     <= '0;
      r_ptr     <= '0;
      r_len     <= '0;
      for (int i = 0; i < 2**IW; i++) r_pat[i] <= C_RST_CHAR;
      for (int i = 0; i < NREQ; i++)  r_ctx[i] <= '0;
`ifdef MATCH_CNT_EN
      for (int i = 0; i < NREQ; i++)  r_cnt[i] <= '0;
`endif
    end else begin
      r_eureka <= 1'b0;
      case (r_state)
        LOAD: begin
          if (cfg_we && ({1'b0, cfg_addr} < C_PMAX)) r_pat[cfg_addr] <= cfg_data;
          if (w_start_ok) begin
            r_len     <= cfg_len;
            r_state   <= RUN;
            r_running <= 1'b1;
            for (int i = 0; i < NREQ; i++) r_ctx[i] <= '0;
`ifdef MATCH_CNT_EN
            for (int i = 0; i < NREQ; i++) r_cnt[i] <= '0;
`endif
          end
        end
        RUN: begin
          if (cfg_stop) begin
            r_state   <= LOAD;
            r_running <= 1'b0;
            for (int i = 0; i < NREQ; i++) r_ctx[i] <= '0;
          end else if (w_any) begin
            r_ptr <= w_ptr_nxt;
            // No KMP fallback: a mismatch only checks whether c restarts the pattern.
            if (w_hit && w_last) begin
              r_ctx[w_gidx] <= '0;
              r_eureka      <= 1'b1;
              r_eid         <= w_gidx;
`ifdef MATCH_CNT_EN
              if (r_cnt[w_gidx] != 16'hFFFF) r_cnt[w_gidx] <= r_cnt[w_gidx] + 16'd1;
`endif
            end else if (w_hit) begin
              r_ctx[w_gidx] <= w_k + IW'(1);
            end else begin
              r_ctx[w_gidx] <= w_first ? IW'(1) : '0;
            end
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_match_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seq_match_arb : directed, table-driven and random checks of            |
// | seq_match_arb against a behavioural matcher model. Rev 1.0                |
// +--------------------------------------------------------------------------+
module tb_seq_match_arb;

  localparam int NREQ = 4;
  localparam int PMAX = 8;
  localparam int IW   = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               cfg_we, cfg_start, cfg_stop;
  logic [IW-1:0]      cfg_addr, cfg_len;
  logic [7:0]         cfg_data;
  logic [NREQ-1:0]    req;
  logic [NREQ*8-1:0]  din;
  logic [NREQ-1:0]    ack;
  logic               running, eureka;
  logic [1:0]         eureka_id;

  always #5 clk = ~clk;

  seq_match_arb #(.NREQ(NREQ), .PMAX(PMAX), .IW(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_len   (cfg_len),
    .cfg_start (cfg_start),
    .cfg_stop  (cfg_stop),
    .req       (req),
    .din       (din),
    .ack       (ack),
    .running   (running),
    .eureka    (eureka),
    .eureka_id (eureka_id)
  );

  int nchecks = 0;
  int nerr    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pattern as a byte array, one progress index per stream.
  bit              m_run;
  int              m_len;
  byte unsigned    m_pat [PMAX];
  int              m_ctx [NREQ];
  int              m_ptr;
  logic [NREQ-1:0] m_ack;
  bit              m_eur;
  int              m_id;

  logic [NREQ-1:0] obs_ack;
  logic            obs_eur;
  logic [1:0]      obs_id;

  task automatic model_reset();
    m_run = 0; m_len = 0; m_ptr = 0;
    for (int i = 0; i < PMAX; i++) m_pat[i] = 8'h00;
    for (int i = 0; i < NREQ; i++) m_ctx[i] = 0;
  endtask

  task automatic tick();
    int g;
    int k;
    byte unsigned c;
    @(negedge clk);
    obs_ack = ack;
    m_ack = '0;
    m_eur = 0;
    g = -1;
    if (m_run && !cfg_stop)
      for (int off = 0; off < NREQ; off++)
        if (g < 0 && req[(m_ptr + off) % NREQ]) g = (m_ptr + off) % NREQ;
    if (g >= 0) m_ack[g] = 1'b1;
    if (rst) chk("ack", ack, m_ack);
    if (!rst) begin
      model_reset();
      m_ack = '0;
    end else if (!m_run) begin
      if (cfg_we && int'(cfg_addr) < PMAX) m_pat[int'(cfg_addr)] = cfg_data;
      if (cfg_start && int'(cfg_len) >= 1 && int'(cfg_len) <= PMAX) begin
        m_len = int'(cfg_len);
        m_run = 1;
        for (int i = 0; i < NREQ; i++) m_ctx[i] = 0;
      end
    end else if (cfg_stop) begin
      m_run = 0;
      for (int i = 0; i < NREQ; i++) m_ctx[i] = 0;
    end else if (g >= 0) begin
      m_ptr = (g + 1) % NREQ;
      c = din[8*g +: 8];
      k = m_ctx[g];
      if (c == m_pat[k]) begin
        if (k + 1 == m_len) begin
          m_ctx[g] = 0; m_eur = 1; m_id = g;
        end else m_ctx[g] = k + 1;
      end else m_ctx[g] = (c == m_pat[0]) ? 1 : 0;
    end
    @(posedge clk);
    #1;
    chk("running", running, m_run);
    chk("eureka", eureka, m_eur);
    if (m_eur) chk("eureka_id", eureka_id, m_id);
    obs_eur = eureka;
    obs_id  = eureka_id;
  endtask

  task automatic idle();
    cfg_we = 0; cfg_addr = '0; cfg_data = '0; cfg_len = '0;
    cfg_start = 0; cfg_stop = 0; req = '0; din = '0;
  endtask

  task automatic load(input string s);
    for (int i = 0; i < s.len(); i++) begin
      cfg_we = 1; cfg_addr = IW'(i); cfg_data = s[i];
      tick();
    end
    cfg_we = 0; cfg_len = IW'(s.len()); cfg_start = 1;
    tick();
    cfg_start = 0;
  endtask

  task automatic stop();
    cfg_stop = 1;
    tick();
    cfg_stop = 0;
  endtask

  task automatic send(input int r, input string s, output int ne, output int pm, output int lid);
    ne = 0; pm = 0; lid = -1;
    for (int i = 0; i < s.len(); i++) begin
      req = '0; req[r] = 1'b1; din[8*r +: 8] = s[i];
      tick();
      chk("send_ack", obs_ack, 32'(1) << r);
      if (obs_eur) begin ne++; pm |= (1 << i); lid = int'(obs_id); end
    end
    req = '0;
  endtask

  typedef struct {
    logic [NREQ-1:0]   req;
    logic [NREQ*8-1:0] din;
    logic [NREQ-1:0]   ack;
    logic              eur;
    logic [1:0]        id;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ne, pm, lid, n, len;
    string rara, alph, s;
    bit pend [NREQ];
    rara = "RARA";
    alph = "RAB";

    idle();
    model_reset();
    rst = 0;
    tick();
    req = '1;
    tick();
    rst = 1;
    tick();
    chk("rst_running", running, 0);
    chk("rst_eureka", eureka, 0);
    chk("load_ack_zero", obs_ack, 0);
    req = '0;

    load("HOMEWORK");
    chk("hw_running", running, 1);
    send(0, "HOMEWORK", ne, pm, lid);
    chk("hw_count", ne, 1); chk("hw_pos", pm, 1 << 7); chk("hw_id", lid, 0);

    send(0, "HOHOMEWORK", ne, pm, lid);
    chk("restart_count", ne, 1); chk("restart_pos", pm, 1 << 9);

    stop();
    load("RARA");
    send(1, "RARARARA", ne, pm, lid);
    chk("nonovl_count", ne, 2); chk("nonovl_pos", pm, (1 << 3) | (1 << 7)); chk("nonovl_id", lid, 1);

    // Fairness table: all four streams held high, each sends RARA.
    rst = 0; tick(); rst = 1;
    load("RARA");
    for (int i = 0; i < 16; i++) begin
      tbl[i].req = '1;
      for (int j = 0; j < NREQ; j++) begin
        n = (i - j + 3) / 4;
        tbl[i].din[8*j +: 8] = (n < 4) ? rara[n] : "X";
      end
      tbl[i].ack = NREQ'(1) << (i % NREQ);
      tbl[i].eur = (i >= 12);
      tbl[i].id  = 2'(i - 12);
    end
    for (int i = 0; i < 16; i++) begin
      req = tbl[i].req; din = tbl[i].din;
      tick();
      chk("tbl_ack", obs_ack, tbl[i].ack);
      chk("tbl_eur", obs_eur, tbl[i].eur);
      if (tbl[i].eur) chk("tbl_id", obs_id, tbl[i].id);
    end
    req = '0;

    // Stop mid-pattern (start+stop together), then restart: prefix must be lost.
    send(0, "RAR", ne, pm, lid);
    chk("prefix_count", ne, 0);
    cfg_stop = 1; cfg_start = 1; cfg_len = 4; req = 4'b0001; din[7:0] = "A";
    tick();
    chk("stop_ack", obs_ack, 0); chk("stop_running", running, 0);
    cfg_stop = 0; cfg_start = 0;
    tick();
    chk("loadhold_ack", obs_ack, 0);
    cfg_start = 1;
    tick();
    cfg_start = 0;
    chk("restart_ack", obs_ack, 0); chk("restart_running", running, 1);
    send(0, "A", ne, pm, lid);
    chk("stale_prefix", ne, 0);
    send(0, "RARA", ne, pm, lid);
    chk("after_stop_count", ne, 1); chk("after_stop_pos", pm, 1 << 3);

    // Reset mid-stream, then illegal lengths keep LOAD.
    send(2, "RAR", ne, pm, lid);
    rst = 0; req = 4'b0100; din[23:16] = "A";
    tick();
    chk("midrst_running", running, 0); chk("midrst_eureka", eureka, 0);
    rst = 1; req = '0;
    cfg_start = 1; cfg_len = 0;
    tick();
    chk("len0_running", running, 0);
    cfg_len = 9;
    tick();
    chk("len9_running", running, 0);
    cfg_start = 0;
    cfg_we = 1; cfg_addr = 8; cfg_data = "Z";
    tick();
    cfg_we = 0;

    // Random rounds with random patterns (round 0 exercises len==1).
    for (int i = 0; i < NREQ; i++) pend[i] = 0;
    for (int r = 0; r < 6; r++) begin
      len = (r == 0) ? 1 : int'($urandom_range(1, PMAX));
      s = "";
      for (int i = 0; i < len; i++) s = {s, alph.substr(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)) * 0 + 0)};
      s = "";
      for (int i = 0; i < len; i++) begin
        n = int'($urandom_range(0, 2));
        s = {s, alph.substr(n, n)};
      end
      if (m_run) stop();
      load(s);
      for (int cyc = 0; cyc < 300; cyc++) begin
        for (int i = 0; i < NREQ; i++) begin
          if (!pend[i] && $urandom_range(0, 1) == 1) begin
            pend[i] = 1;
            n = int'($urandom_range(0, 2));
            din[8*i +: 8] = alph[n];
          end
          req[i] = pend[i];
        end
        cfg_stop  = m_run && ($urandom_range(0, 63) == 0);
        cfg_start = !m_run;
        cfg_len   = IW'(len);
        tick();
        for (int i = 0; i < NREQ; i++) if (m_ack[i]) pend[i] = 0;
      end
      idle();
      for (int i = 0; i < NREQ; i++) pend[i] = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
`default_nettype wire
